// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: MEM-priority arbiter sharing one memory bus between IF and MEM stages.
// Define ARB_PERF_EN to enable the conflict/busy performance counters.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              mem_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic [31:0]       perf_conflict_cnt,
  output logic [31:0]       perf_busy_cnt
);
  typedef enum logic [1:0] {IDLE, SERVE_IF, SERVE_MEM} state_t;
  state_t state;
  logic if_elig, mem_elig;
  // a requester being acked this cycle is not eligible, so it cannot be granted twice
  assign if_elig   = if_req & ~if_ack;
  assign mem_elig  = mem_req & ~mem_ack;
  assign if_stall  = if_req & ~if_ack;
  assign mem_stall = mem_req & ~mem_ack;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      case (state)
        IDLE:
          if (mem_elig) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
            state     <= SERVE_MEM;
          end else if (if_elig) begin
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
            state     <= SERVE_IF;
          end
        SERVE_IF:
          if (bus_ack) begin
            if_rdata <= bus_rdata;
            if_ack   <= 1'b1;
            bus_req  <= 1'b0;
            state    <= IDLE;
          end
        SERVE_MEM:
          if (bus_ack) begin
            mem_rdata <= bus_rdata;
            mem_ack   <= 1'b1;
            bus_req   <= 1'b0;
            state     <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict_cnt <= '0;
      perf_busy_cnt     <= '0;
    end else begin
      if (if_req && (state == SERVE_MEM || (state == IDLE && mem_elig)))
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      if (bus_req)
        perf_busy_cnt <= perf_busy_cnt + 32'd1;
    end
  end
`else
  assign perf_conflict_cnt = '0;
  assign perf_busy_cnt     = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req = 1'b0, if_ack, if_stall;
  logic [31:0] if_addr = '0, if_rdata;
  logic        mem_req = 1'b0, mem_we = 1'b0, mem_ack, mem_stall;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
  logic        bus_req, bus_we, bus_ack = 1'b0;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = '0;
  logic [31:0] perf_conflict_cnt, perf_busy_cnt;
  logic [31:0] conf_base, busy_base;
  int checks = 0, errors = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .perf_conflict_cnt(perf_conflict_cnt), .perf_busy_cnt(perf_busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc();
    cyc();
    chk("rst_bus_req", {31'd0, bus_req}, 0);
    chk("rst_bus_we", {31'd0, bus_we}, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_if_ack", {31'd0, if_ack}, 0);
    chk("rst_mem_ack", {31'd0, mem_ack}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_perf_conf", perf_conflict_cnt, 0);
    chk("rst_perf_busy", perf_busy_cnt, 0);
    rst = 1'b0;
    cyc();
    // single fetch, zero wait
    if_req = 1'b1; if_addr = 32'h40;
    #1;
    chk("f_stall_c0", {31'd0, if_stall}, 1);
    chk("f_busreq_c0", {31'd0, bus_req}, 0);
    cyc();
    chk("f_busreq_c1", {31'd0, bus_req}, 1);
    chk("f_busaddr_c1", bus_addr, 32'h40);
    chk("f_buswe_c1", {31'd0, bus_we}, 0);
    chk("f_stall_c1", {31'd0, if_stall}, 1);
    bus_ack = 1'b1; bus_rdata = 32'h2108000A;
    cyc();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    chk("f_ack_c2", {31'd0, if_ack}, 1);
    chk("f_rdata_c2", if_rdata, 32'h2108000A);
    chk("f_stall_c2", {31'd0, if_stall}, 0);
    chk("f_busreq_c2", {31'd0, bus_req}, 0);
    if_req = 1'b0;
    cyc();
    chk("f_ack_c3", {31'd0, if_ack}, 0);
    chk("f_rdata_hold", if_rdata, 32'h2108000A);
    // store with 3 wait states
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEADBEEF;
    cyc();
    for (int i = 1; i <= 4; i++) begin
      chk("s_busreq", {31'd0, bus_req}, 1);
      chk("s_buswe", {31'd0, bus_we}, 1);
      chk("s_busaddr", bus_addr, 32'h100);
      chk("s_buswdata", bus_wdata, 32'hDEADBEEF);
      chk("s_memack", {31'd0, mem_ack}, 0);
      chk("s_stall", {31'd0, mem_stall}, 1);
      if (i == 2) mem_addr = 32'h999;
      bus_ack = (i == 4);
      cyc();
    end
    bus_ack = 1'b0;
    chk("s_memack_c5", {31'd0, mem_ack}, 1);
    chk("s_stall_c5", {31'd0, mem_stall}, 0);
    chk("s_busreq_c5", {31'd0, bus_req}, 0);
    mem_req = 1'b0; mem_we = 1'b0;
    cyc();
    chk("s_memack_c6", {31'd0, mem_ack}, 0);
    // conflict: MEM first, IF immediately after
    if_req = 1'b1; if_addr = 32'h44; mem_req = 1'b1; mem_addr = 32'h200;
    conf_base = perf_conflict_cnt; busy_base = perf_busy_cnt;
    cyc();
    chk("c_busaddr_c1", bus_addr, 32'h200);
    chk("c_buswe_c1", {31'd0, bus_we}, 0);
    chk("c_ifstall_c1", {31'd0, if_stall}, 1);
    cyc();
    bus_ack = 1'b1; bus_rdata = 32'hAAAA5555;
    cyc();
    bus_ack = 1'b0;
    chk("c_memack_c3", {31'd0, mem_ack}, 1);
    chk("c_memrdata_c3", mem_rdata, 32'hAAAA5555);
    chk("c_ifack_c3", {31'd0, if_ack}, 0);
    mem_req = 1'b0;
    cyc();
    chk("c_busreq_c4", {31'd0, bus_req}, 1);
    chk("c_busaddr_c4", bus_addr, 32'h44);
`ifdef ARB_PERF_EN
    chk("c_perf_conf", perf_conflict_cnt, conf_base + 32'd3);
`endif
    bus_ack = 1'b1; bus_rdata = 32'h11112222;
    cyc();
    bus_ack = 1'b0;
    chk("c_ifack_c5", {31'd0, if_ack}, 1);
    chk("c_ifrdata_c5", if_rdata, 32'h11112222);
    chk("c_memrdata_hold", mem_rdata, 32'hAAAA5555);
`ifdef ARB_PERF_EN
    chk("c_perf_busy", perf_busy_cnt, busy_base + 32'd3);
`endif
    if_req = 1'b0;
    cyc();
    // no double grant while req held through the ack cycle
    if_req = 1'b1; if_addr = 32'h48;
    cyc();
    chk("d_busreq_c1", {31'd0, bus_req}, 1);
    bus_ack = 1'b1; bus_rdata = 32'h12345678;
    cyc();
    bus_ack = 1'b0;
    chk("d_ifack_c2", {31'd0, if_ack}, 1);
    cyc();
    chk("d_busreq_c3", {31'd0, bus_req}, 0);
    chk("d_ifack_c3", {31'd0, if_ack}, 0);
    if_req = 1'b0;
    cyc();
    chk("d_busreq_c4", {31'd0, bus_req}, 0);
    // reset in the middle of a 5-wait load
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300;
    cyc();
    chk("r_busreq_c1", {31'd0, bus_req}, 1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; mem_req = 1'b0;
    chk("r_busreq_c3", {31'd0, bus_req}, 0);
    chk("r_busaddr_c3", bus_addr, 0);
    chk("r_ifrdata_c3", if_rdata, 0);
    chk("r_memrdata_c3", mem_rdata, 0);
    chk("r_perf_busy_c3", perf_busy_cnt, 0);
    chk("r_perf_conf_c3", perf_conflict_cnt, 0);
    cyc();
    bus_ack = 1'b1; bus_rdata = 32'hBADBAD00;
    cyc();
    bus_ack = 1'b0;
    chk("r_memack_c5", {31'd0, mem_ack}, 0);
    chk("r_busreq_c5", {31'd0, bus_req}, 0);
    chk("r_memrdata_c5", mem_rdata, 0);
    cyc();
`ifdef ARB_PERF_EN
    // busy counter wraps after one bus cycle from all-ones
    force dut.perf_busy_cnt = 32'hFFFFFFFF;
    #1;
    release dut.perf_busy_cnt;
    cyc();
    if_req = 1'b1; if_addr = 32'h80;
    cyc();
    bus_ack = 1'b1;
    cyc();
    bus_ack = 1'b0; if_req = 1'b0;
    chk("w_busy_wrap", perf_busy_cnt, 32'h0);
    cyc();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
